// File: rtl/lap_stopwatch_if.sv
// Lap read-back port between the stopwatch and the display/menu logic.
// Index is driven by the reader; data/valid return one clock later.
interface lap_stopwatch_if #(
    parameter int IW = 3
) ();
    logic [IW-1:0] LapRdIdx;
    logic [19:0]   LapRdData;
    logic          LapRdValid;

    modport master (
        output LapRdIdx,
        input  LapRdData,
        input  LapRdValid
    );

    modport slave (
        input  LapRdIdx,
        output LapRdData,
        output LapRdValid
    );
endinterface

// File: rtl/lap_stopwatch.sv
// Stopwatch core: prescaled tick, min:sec:centi counter, split display,
// circular lap memory with registered read-back.
module lap_stopwatch #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MIN_MAX   = 100,
    parameter int LAP_DEPTH = 8,
    parameter int IW        = $clog2(LAP_DEPTH)
) (
    input  logic          Clk_50Mhz,
    input  logic          Rst_n,
    input  logic          Button1Sw,
    input  logic          Button2Sw,
    input  logic          Button3Sw,
    lap_stopwatch_if.slave rd,
    output logic [6:0]    CentiSecSW,
    output logic [5:0]    SecSW,
    output logic [6:0]    MinSW,
    output logic          RunningSW,
    output logic          BlinkSW,
    output logic [IW:0]   LapCount,
    output logic          LapOverflow,
    output logic          WrapPulse
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPLIT, S_STOP} state_t;

    state_t        r_state, w_nxt;
    logic [2:0]    r_s1, r_s2, r_s3;
    logic [2:0]    w_rise;
    logic          w_ev1, w_ev2, w_ev3;
    logic          w_cap, w_clr, w_run, w_tick, w_wrap;
    logic [PW-1:0] r_pre;
    logic [6:0]    r_centi, r_min, w_c_n, w_m_n;
    logic [5:0]    r_sec, w_s_n;
    logic [19:0]   w_live, r_frz;
    logic [19:0]   r_mem [LAP_DEPTH];
    logic [IW-1:0] r_wptr, w_ridx;
    logic [IW:0]   r_cnt;
    logic          r_ovf, r_wrap, w_rvld;
    logic [19:0]   r_rd_data;
    logic          r_rd_vld;
    logic [19:0]   r_disp;

    // Two-flop synchroniser plus edge detector; one event per press.
    always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= {Button3Sw, Button2Sw, Button1Sw};
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_ev2  = w_rise[1];
    assign w_ev1  = w_rise[0] & ~w_rise[1];
    assign w_ev3  = w_rise[2] & ~|w_rise[1:0];

    always_comb begin
        w_nxt = r_state;
        w_cap = 1'b0;
        w_clr = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_ev1) w_nxt = S_RUN;
            S_RUN: begin
                if (w_ev1) begin
                    w_nxt = S_STOP;
                end else if (w_ev3) begin
                    w_nxt = S_SPLIT;
                    w_cap = 1'b1;
                end
            end
            S_SPLIT: begin
                if (w_ev2)      w_nxt = S_RUN;
                else if (w_ev1) w_nxt = S_STOP;
                else if (w_ev3) w_cap = 1'b1;
            end
            S_STOP: begin
                if (w_ev2) begin
                    w_nxt = S_IDLE;
                    w_clr = 1'b1;
                end else if (w_ev1) begin
                    w_nxt = S_RUN;
                end
            end
        endcase
    end

    assign w_run  = (r_state == S_RUN) || (r_state == S_SPLIT);
    assign w_tick = w_run && (r_pre == PW'(DIV - 1));
    assign w_live = {r_min, r_sec, r_centi};

    always_comb begin
        w_c_n  = r_centi;
        w_s_n  = r_sec;
        w_m_n  = r_min;
        w_wrap = 1'b0;
        if (w_tick) begin
            if (r_centi == 7'd99) begin
                w_c_n = '0;
                if (r_sec == 6'd59) begin
                    w_s_n = '0;
                    if (r_min == 7'(MIN_MAX - 1)) begin
                        w_m_n  = '0;
                        w_wrap = 1'b1;
                    end else begin
                        w_m_n = r_min + 7'd1;
                    end
                end else begin
                    w_s_n = r_sec + 6'd1;
                end
            end else begin
                w_c_n = r_centi + 7'd1;
            end
        end
    end

    always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_centi <= '0;
            r_sec   <= '0;
            r_min   <= '0;
            r_wrap  <= 1'b0;
            r_frz   <= '0;
            r_disp  <= '0;
        end else begin
            r_state <= w_nxt;
            r_wrap  <= w_wrap;
            if (w_clr) begin
                r_pre   <= '0;
                r_centi <= '0;
                r_sec   <= '0;
                r_min   <= '0;
            end else begin
                if (w_tick)     r_pre <= '0;
                else if (w_run) r_pre <= r_pre + PW'(1);
                r_centi <= w_c_n;
                r_sec   <= w_s_n;
                r_min   <= w_m_n;
            end
            if (w_cap) r_frz <= w_live;
            r_disp <= (r_state == S_SPLIT) ? r_frz : w_live;
        end
    end

    // Lap storage contents are deliberately left out of reset.
    always_ff @(posedge Clk_50Mhz) begin
        if (w_cap) r_mem[r_wptr] <= w_live;
    end

    assign w_ridx = r_wptr - IW'(1) - rd.LapRdIdx;
    assign w_rvld = {1'b0, rd.LapRdIdx} < r_cnt;

    always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wptr    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            if (w_clr) begin
                r_wptr <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else if (w_cap) begin
                r_wptr <= r_wptr + IW'(1);
                if (r_cnt == (IW+1)'(LAP_DEPTH)) r_ovf <= 1'b1;
                else r_cnt <= r_cnt + (IW+1)'(1);
            end
            r_rd_vld  <= w_rvld;
            r_rd_data <= w_rvld ? r_mem[w_ridx] : '0;
        end
    end

    assign CentiSecSW    = r_disp[6:0];
    assign SecSW         = r_disp[12:7];
    assign MinSW         = r_disp[19:13];
    assign RunningSW     = w_run;
    assign BlinkSW       = (r_state == S_SPLIT);
    assign LapCount      = r_cnt;
    assign LapOverflow   = r_ovf;
    assign WrapPulse     = r_wrap;
    assign rd.LapRdData  = r_rd_data;
    assign rd.LapRdValid = r_rd_vld;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench: main DUT at 10 clocks/tick, second DUT with 2 clocks/tick
// and 2-minute modulus to reach the wrap point quickly.
module tb_lap_stopwatch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] btn_a, btn_w;

    logic [6:0] a_centi, a_min;
    logic [5:0] a_sec;
    logic       a_run, a_blink, a_ovf, a_wrap;
    logic [3:0] a_cnt;

    logic [6:0] w_centi, w_min;
    logic [5:0] w_sec;
    logic       w_run, w_blink, w_ovf, w_wrap;
    logic [1:0] w_cnt;

    lap_stopwatch_if #(.IW(3)) if_a ();
    lap_stopwatch_if #(.IW(1)) if_w ();

    lap_stopwatch #(
        .CLK_HZ(1000), .TICK_HZ(100), .MIN_MAX(100), .LAP_DEPTH(8)
    ) u_dut (
        .Clk_50Mhz(clk), .Rst_n(rst_n),
        .Button1Sw(btn_a[0]), .Button2Sw(btn_a[1]), .Button3Sw(btn_a[2]),
        .rd(if_a.slave),
        .CentiSecSW(a_centi), .SecSW(a_sec), .MinSW(a_min),
        .RunningSW(a_run), .BlinkSW(a_blink),
        .LapCount(a_cnt), .LapOverflow(a_ovf), .WrapPulse(a_wrap)
    );

    lap_stopwatch #(
        .CLK_HZ(2), .TICK_HZ(1), .MIN_MAX(2), .LAP_DEPTH(2)
    ) u_wrap (
        .Clk_50Mhz(clk), .Rst_n(rst_n),
        .Button1Sw(btn_w[0]), .Button2Sw(btn_w[1]), .Button3Sw(btn_w[2]),
        .rd(if_w.slave),
        .CentiSecSW(w_centi), .SecSW(w_sec), .MinSW(w_min),
        .RunningSW(w_run), .BlinkSW(w_blink),
        .LapCount(w_cnt), .LapOverflow(w_ovf), .WrapPulse(w_wrap)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_a(input string tag, input int mn, input int sc,
                         input int cs);
        check({tag, ".min"}, 32'(a_min), mn);
        check({tag, ".sec"}, 32'(a_sec), sc);
        check({tag, ".centi"}, 32'(a_centi), cs);
    endtask

    task automatic chk_w(input string tag, input int mn, input int sc,
                         input int cs, input int wp);
        check({tag, ".min"}, 32'(w_min), mn);
        check({tag, ".sec"}, 32'(w_sec), sc);
        check({tag, ".centi"}, 32'(w_centi), cs);
        check({tag, ".wrap"}, 32'(w_wrap), wp);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Held for 4 clocks; the state update lands on the 3rd rising edge.
    task automatic press(input bit on_wrap, input logic [2:0] m);
        if (on_wrap) btn_w = m;
        else btn_a = m;
        clocks(4);
        btn_a = '0;
        btn_w = '0;
    endtask

    task automatic rd_a(input string tag, input logic [2:0] idx,
                        input int data, input int vld);
        if_a.LapRdIdx = idx;
        clocks(1);
        check({tag, ".data"}, 32'(if_a.LapRdData), data);
        check({tag, ".vld"}, 32'(if_a.LapRdValid), vld);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_a = '0;
        btn_w = '0;
        if_a.LapRdIdx = '0;
        if_w.LapRdIdx = '0;
        clocks(2);
        chk_a("rst", 0, 0, 0);
        check("rst.run", 32'(a_run), 0);
        check("rst.cnt", 32'(a_cnt), 0);
        check("rst.vld", 32'(if_a.LapRdValid), 0);
        rst_n = 1'b1;
        clocks(2);

        // Start, run 1000 clocks, stop and hold
        press(1'b0, 3'b001);
        check("start.run", 32'(a_run), 1);
        clocks(1000);
        chk_a("run1s", 0, 1, 0);
        press(1'b0, 3'b001);
        check("stop.run", 32'(a_run), 0);
        chk_a("stop", 0, 1, 0);
        clocks(50);
        chk_a("stop.hold", 0, 1, 0);

        // Clear from STOP, restart, reset button ignored in RUN
        press(1'b0, 3'b010);
        chk_a("clr", 0, 0, 0);
        check("clr.run", 32'(a_run), 0);
        press(1'b0, 3'b001);
        press(1'b0, 3'b010);
        check("b2run.run", 32'(a_run), 1);
        check("b2run.blink", 32'(a_blink), 0);

        // Split at 0:00:25
        clocks(247);
        press(1'b0, 3'b100);
        check("split.blink", 32'(a_blink), 1);
        chk_a("split", 0, 0, 25);
        check("split.cnt", 32'(a_cnt), 1);
        clocks(100);
        chk_a("split.frz", 0, 0, 25);
        press(1'b0, 3'b010);
        check("rel.blink", 32'(a_blink), 0);
        chk_a("rel", 0, 0, 35);

        // Two more laps, then stop from SPLIT
        press(1'b0, 3'b100);
        clocks(20);
        press(1'b0, 3'b100);
        chk_a("lap3", 0, 0, 38);
        press(1'b0, 3'b001);
        check("stop2.run", 32'(a_run), 0);
        check("stop2.blink", 32'(a_blink), 0);
        chk_a("stop2", 0, 0, 39);
        check("stop2.cnt", 32'(a_cnt), 3);
        rd_a("rd5", 3'd5, 0, 0);
        rd_a("rd0", 3'd0, 38, 1);
        rd_a("rd2", 3'd2, 25, 1);
        rd_a("rd3", 3'd3, 0, 0);

        // Start and clear together in STOP: clear wins
        press(1'b0, 3'b011);
        check("both.run", 32'(a_run), 0);
        check("both.cnt", 32'(a_cnt), 0);
        check("both.ovf", 32'(a_ovf), 0);
        clocks(20);
        chk_a("both", 0, 0, 0);

        // Ten laps into an 8-deep memory, laps hold centi 0..9
        if_a.LapRdIdx = '0;
        press(1'b0, 3'b001);
        for (int k = 0; k < 10; k++) begin
            press(1'b0, 3'b100);
            clocks(6);
        end
        check("ten.cnt", 32'(a_cnt), 8);
        check("ten.ovf", 32'(a_ovf), 1);
        chk_a("ten.frz", 0, 0, 9);
        rd_a("ten.rd0", 3'd0, 9, 1);
        if_a.LapRdIdx = 3'd7;
        #1;
        check("ten.lat", 32'(if_a.LapRdData), 9);
        @(negedge clk);
        check("ten.rd7", 32'(if_a.LapRdData), 2);

        // Asynchronous reset while in SPLIT
        rst_n = 1'b0;
        #1;
        chk_a("arst", 0, 0, 0);
        check("arst.run", 32'(a_run), 0);
        check("arst.blink", 32'(a_blink), 0);
        check("arst.cnt", 32'(a_cnt), 0);
        check("arst.ovf", 32'(a_ovf), 0);
        check("arst.vld", 32'(if_a.LapRdValid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clocks(2);

        // Wrap at 1:59:99 on the fast instance
        press(1'b1, 3'b001);
        clocks(23998);
        chk_w("pre", 1, 59, 99, 0);
        clocks(1);
        chk_w("wrap", 1, 59, 99, 1);
        clocks(1);
        chk_w("zero", 0, 0, 0, 0);
        clocks(2);
        chk_w("post", 0, 0, 1, 0);
        check("post.run", 32'(w_run), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
